branch_commit: RTL
==================

Name: branch_commit

Overview:
Commit-side consumer of the branch/compare ALU result interface. It captures a valid result and returns the one-cycle clear to the ALU. It then writes the result register, redirects the PC and flushes the front end on a mispredict, and raises a trap on illegal or overflowed results. It sits between the branch ALU output stage and the register file, fetch PC and trap logic, and keeps retire and mispredict counters.

Parameters:
XLEN, core_config_pkg::XLEN (32), data/address width
REG_ADDR_W, core_config_pkg::REG_ADDR_W (5), register index width
FLUSH_CYCLES, 2, cycles flush is held after redirect; 0 skips FLUSH
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU result valid
alu_res  in  XLEN  register write value
alu_jmp  in  XLEN  taken/jump target
alu_rd  in  REG_ADDR_W  destination register
alu_req  in  1  branch/jump actually taken
alu_mispredict  in  1  prediction wrong
alu_i_error  in  1  unknown instruction
alu_o_error  in  1  arithmetic carry-out on res/jmp
fallthrough_pc  in  XLEN  sequential PC of the instruction, valid with alu_valid
alu_clear  out  1  one-cycle acknowledge to ALU
wb_valid  out  1  register write request
wb_rd  out  REG_ADDR_W  write index
wb_data  out  XLEN  write data
wb_ready  in  1  regfile accepts write
pc_load  out  1  PC redirect request
pc_target  out  XLEN  redirect address
pc_ack  in  1  fetch accepted redirect
flush  out  1  front-end flush
trap  out  1  trap request
trap_cause  out  2  1 = illegal instr, 2 = overflow
trap_ack  in  1  trap taken
busy  out  1  state != IDLE
retire_cnt  out  CNT_W  committed results
mispredict_cnt  out  CNT_W  redirects issued

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE. Reset mid-operation abandons the operation with no pending write, redirect or trap.
- States: IDLE, WB, REDIRECT, FLUSH, TRAP.
- IDLE, alu_valid=1: capture res, jmp, rd, req, mispredict, both errors and fallthrough_pc.
  - Register alu_clear=1 for exactly the next cycle.
  - alu_valid is ignored in every state other than IDLE.
- Capture priority:
  - alu_i_error → TRAP, cause 1.
  - Else alu_o_error → TRAP, cause 2.
  - Else rd != 0 → WB.
  - Else mispredict → REDIRECT.
  - Else stay in IDLE and retire.
- WB: wb_valid=1 with the captured rd/data, held stable until the cycle wb_ready=1 (wb_ready may already be 1 on the first WB cycle). That cycle completes the write. Next state is REDIRECT if mispredict, else IDLE.
- REDIRECT:
  - pc_target = req ? jmp : fallthrough_pc.
  - pc_load is held until pc_ack.
  - On ack: mispredict_cnt++, flush counter loaded. Next state is FLUSH if FLUSH_CYCLES > 0, else IDLE.
- FLUSH: flush=1 for exactly FLUSH_CYCLES cycles, then IDLE.
- TRAP: trap=1 and trap_cause held until trap_ack, then IDLE. No write, no redirect, no retire increment.
- retire_cnt increments once per non-trapped instruction, on its final transition back to IDLE. Both counters wrap modulo 2^CNT_W.
- Minimum occupancy is 1 cycle (IDLE retire, no write/redirect). The next capture is possible 2 cycles after the previous one, because of the clear cycle.
- Outputs are registered. No combinational path from alu_* to wb_*, pc_* or trap.

Decomposition:
- core_config_pkg gains commit_state_t (the 5 states) and trap_cause_t with TRAP_ILLEGAL=2'd1 and TRAP_OVERFLOW=2'd2.
- Sub-module perf_counter (CNT_W, inc input, wrapping register), instantiated twice.

Test Plan:
- SLT result: rd=5, res=1, no mispredict, wb_ready=1 → wb_valid 1 cycle with rd=5, data=1; alu_clear pulse; retire_cnt=1; no pc_load.
- Taken mispredict: rd=0, req=1, jmp=0x100, pc_ack after 1 cycle → pc_target=0x100; flush high for exactly 2 cycles; mispredict_cnt=1; then idle.
- JALR-like: rd=1, res=0x44, mispredict, req=0, fallthrough_pc=0x40, wb_ready low 3 cycles → wb_valid held stable 4 cycles, then pc_target=0x40.
- Error priority: alu_i_error=1 and alu_o_error=1 together → trap_cause=1, held until trap_ack; no wb/pc activity; counters unchanged.
- Reset asserted during FLUSH → all outputs 0 immediately; a new alu_valid after reset is captured normally.
- CNT_W=4, 16 retires → retire_cnt wraps to 0.

Source files
------------

// File: rtl/core_config_pkg.sv
// core_config_pkg: shared core widths plus commit-stage state and trap cause encodings
package core_config_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WB       = 3'd1,
        ST_REDIRECT = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_TRAP     = 3'd4
    } commit_state_t;

    typedef enum logic [1:0] {
        TRAP_NONE     = 2'd0,
        TRAP_ILLEGAL  = 2'd1,
        TRAP_OVERFLOW = 2'd2
    } trap_cause_t;
endpackage

// File: rtl/branch_commit_perf_counter.sv
// perf_counter: wrapping event counter, one increment per cycle inc_i is high
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);
    logic [CNT_W-1:0] cnt_q;

    // count events, wrapping naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else if (inc_i) cnt_q <= cnt_q + 1'b1;

    assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_commit.sv
// branch_commit: commits branch ALU results to regfile, PC redirect/flush and trap logic
module branch_commit
    import core_config_pkg::*;
#(
    parameter int XLEN         = core_config_pkg::XLEN,
    parameter int REG_ADDR_W   = core_config_pkg::REG_ADDR_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_valid,
    input  logic [XLEN-1:0]       alu_res,
    input  logic [XLEN-1:0]       alu_jmp,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic                  alu_req,
    input  logic                  alu_mispredict,
    input  logic                  alu_i_error,
    input  logic                  alu_o_error,
    input  logic [XLEN-1:0]       fallthrough_pc,
    output logic                  alu_clear,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    input  logic                  wb_ready,
    output logic                  pc_load,
    output logic [XLEN-1:0]       pc_target,
    input  logic                  pc_ack,
    output logic                  flush,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    input  logic                  trap_ack,
    output logic                  busy,
    output logic [CNT_W-1:0]      retire_cnt,
    output logic [CNT_W-1:0]      mispredict_cnt
);
    localparam int FW = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES + 1) : 1;

    commit_state_t         state_q, state_d;
    trap_cause_t           cause_q;
    logic [FW-1:0]         fcnt_q, fcnt_d;
    logic [XLEN-1:0]       res_q, jmp_q, ft_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  req_q, misp_q, clear_q;
    logic                  capture, ret_inc, mis_inc;

    // next-state logic; alu_valid is only honoured in IDLE outside the clear cycle
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        mis_inc = 1'b0;
        capture = state_q == ST_IDLE && alu_valid && !clear_q;
        unique case (state_q)
            ST_IDLE:     if (capture) state_d = (alu_i_error || alu_o_error) ? ST_TRAP :
                                                (alu_rd != '0) ? ST_WB :
                                                alu_mispredict ? ST_REDIRECT : ST_IDLE;
            ST_WB:       if (wb_ready) state_d = misp_q ? ST_REDIRECT : ST_IDLE;
            ST_REDIRECT: if (pc_ack) begin
                mis_inc = 1'b1;
                fcnt_d  = FW'(FLUSH_CYCLES);
                state_d = FLUSH_CYCLES > 0 ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q - 1'b1;
                if (fcnt_q <= FW'(1)) state_d = ST_IDLE;
            end
            ST_TRAP:     if (trap_ack) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        ret_inc = state_q != ST_TRAP && state_d == ST_IDLE && (state_q != ST_IDLE || capture);
    end

    // state, flush counter, clear pulse and captured ALU result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            fcnt_q  <= '0;
            clear_q <= 1'b0;
            cause_q <= TRAP_NONE;
            res_q   <= '0;
            jmp_q   <= '0;
            ft_q    <= '0;
            rd_q    <= '0;
            req_q   <= 1'b0;
            misp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            clear_q <= capture;
            if (capture) begin
                cause_q <= alu_i_error ? TRAP_ILLEGAL : TRAP_OVERFLOW;
                res_q   <= alu_res;
                jmp_q   <= alu_jmp;
                ft_q    <= fallthrough_pc;
                rd_q    <= alu_rd;
                req_q   <= alu_req;
                misp_q  <= alu_mispredict;
            end
        end
    end

    assign alu_clear  = clear_q;
    assign wb_valid   = state_q == ST_WB;
    assign wb_rd      = rd_q;
    assign wb_data    = res_q;
    assign pc_load    = state_q == ST_REDIRECT;
    assign pc_target  = req_q ? jmp_q : ft_q;
    assign flush      = state_q == ST_FLUSH;
    assign trap       = state_q == ST_TRAP;
    assign trap_cause = trap ? cause_q : TRAP_NONE;
    assign busy       = state_q != ST_IDLE;

    perf_counter #(.CNT_W(CNT_W)) u_retire (
        .clk(clk), .rst_n(rst_n), .inc_i(ret_inc), .cnt_o(retire_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_mispredict (
        .clk(clk), .rst_n(rst_n), .inc_i(mis_inc), .cnt_o(mispredict_cnt)
    );
endmodule
